// File: rtl/mem_write_checker.sv
// Self-check monitor for the CPU data-memory write port.
// Holds a loadable table of expected (address, data) writes and, once armed,
// matches observed stores against it in strict order or any order. Ends in
// PASS, FAIL (with the offending write captured) or TOUT (cycle budget spent).
//
// Table handshake: exp_we is a single-cycle strobe with no ready; it is
// accepted on any edge outside RUN (and outside reset) when exp_idx names a
// real entry, and silently dropped otherwise.
module mem_write_checker #(
    parameter int                ADDR_W       = 32,
    parameter int                DATA_W       = 32,
    parameter int                NUM_EXP      = 4,
    parameter int                STRICT_ORDER = 1,
    parameter int                IGNORE_EN    = 1,
    parameter logic [ADDR_W-1:0] IGNORE_ADDR  = 'h60,
    parameter int                TIMEOUT_CYC  = 1000,
    localparam int               IDX_W        = $clog2(NUM_EXP)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] data_adr,
    input  logic [DATA_W-1:0] write_data,
    input  logic              exp_we,
    input  logic [IDX_W-1:0]  exp_idx,
    input  logic [ADDR_W-1:0] exp_addr,
    input  logic [DATA_W-1:0] exp_data,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [IDX_W:0]    match_count,
    output logic [ADDR_W-1:0] fail_adr,
    output logic [DATA_W-1:0] fail_data
);

    // Counter only needs to reach TIMEOUT_CYC-1; at that value RUN is left.
    localparam int              CNT_W     = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [IDX_W:0]   MATCH_ALL = (IDX_W + 1)'(NUM_EXP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_PASS,
        S_FAIL,
        S_TOUT
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   tbl_addr [NUM_EXP];
    logic [DATA_W-1:0]   tbl_data [NUM_EXP];
    logic [IDX_W:0]      match_d;
    logic [NUM_EXP-1:0]  mask_q, mask_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   fadr_d;
    logic [DATA_W-1:0]   fdata_d;
    logic                hit;
    logic [IDX_W-1:0]    hit_idx;
    logic                ignored;

    // Find the table entry the current write satisfies, if any.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        if (STRICT_ORDER != 0) begin
            hit_idx = match_count[IDX_W-1:0];
            hit     = (tbl_addr[hit_idx] == data_adr) && (tbl_data[hit_idx] == write_data);
        end else begin
            // Descending scan so the lowest unmatched candidate wins.
            for (int i = NUM_EXP - 1; i >= 0; i--) begin
                if (!mask_q[i] && (tbl_addr[i] == data_adr) && (tbl_data[i] == write_data)) begin
                    hit     = 1'b1;
                    hit_idx = IDX_W'(i);
                end
            end
        end
    end

    // Next-state and next-value logic for the check sequence.
    always_comb begin
        state_d = state_q;
        match_d = match_count;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        fadr_d  = fail_adr;
        fdata_d = fail_data;
        ignored = (IGNORE_EN != 0) && (data_adr == IGNORE_ADDR);
        case (state_q)
            S_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (mem_write && !ignored) begin
                    if (hit) begin
                        mask_d[hit_idx] = 1'b1;
                        match_d         = match_count + 1'b1;
                        if (match_d == MATCH_ALL) begin
                            state_d = S_PASS;
                        end
                    end else begin
                        state_d = S_FAIL;
                        fadr_d  = data_adr;
                        fdata_d = write_data;
                    end
                end
                // A completing write on the last budgeted edge takes priority.
                if ((state_d == S_RUN) && (cnt_q == CNT_LAST)) begin
                    state_d = S_TOUT;
                end
            end
            default: begin
                if (start) begin
                    state_d = S_RUN;
                    match_d = '0;
                    mask_d  = '0;
                    cnt_d   = '0;
                    fadr_d  = '0;
                    fdata_d = '0;
                end
            end
        endcase
    end

    // State, progress and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            match_count <= '0;
            mask_q      <= '0;
            cnt_q       <= '0;
            fail_adr    <= '0;
            fail_data   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state_q     <= state_d;
            match_count <= match_d;
            mask_q      <= mask_d;
            cnt_q       <= cnt_d;
            fail_adr    <= fadr_d;
            fail_data   <= fdata_d;
            busy        <= (state_d == S_RUN);
            done        <= (state_d == S_PASS) || (state_d == S_FAIL) || (state_d == S_TOUT);
            pass        <= (state_d == S_PASS);
            fail        <= (state_d == S_FAIL);
            timeout     <= (state_d == S_TOUT);
        end
    end

    // Expected-write table; contents survive reset so a run can be repeated.
    always_ff @(posedge clk) begin
        if (!reset && exp_we && (state_q != S_RUN) && (int'(exp_idx) < NUM_EXP)) begin
            tbl_addr[exp_idx] <= exp_addr;
            tbl_data[exp_idx] <= exp_data;
        end
    end

endmodule
